// File: rtl/link_page_queue_manager.sv
// link_page_queue_manager
//   Keeps QUEUE_NUM linked lists of pages plus one free list in a shared
//   next-pointer table. An enqueue moves the free-list head page onto the
//   tail of a queue. A dequeue moves a queue's head page onto the free-list tail.
//   After reset the free list is built one entry per cycle (INIT).
//   Each request then takes IDLE -> EXEC -> RESP, with the response two
//   cycles after acceptance.
//   Optional feature macro: LINK_QUEUE_STAT_EN adds per-queue page counters
//   on o_queue_count.
module link_page_queue_manager #(
    parameter int PAGE_NUM_LOG   = 6,
    parameter int QUEUE_NUM      = 4,
    parameter int QUEUE_ID_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_op,
    input  logic [QUEUE_ID_WIDTH-1:0] i_req_queue,
    output logic                      o_rsp_valid,
    output logic [PAGE_NUM_LOG-1:0]   o_rsp_page,
    output logic                      o_rsp_error,
    output logic [QUEUE_NUM-1:0]      o_queue_empty,
    output logic [PAGE_NUM_LOG:0]     o_free_count,
    output logic                      o_init_done
`ifdef LINK_QUEUE_STAT_EN
    ,
    output logic [QUEUE_NUM*(PAGE_NUM_LOG+1)-1:0] o_queue_count
`endif
);

    localparam int PAGE_NUM = 1 << PAGE_NUM_LOG;
    localparam int QI_W     = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;

    typedef logic [PAGE_NUM_LOG-1:0] page_t;
    typedef logic [PAGE_NUM_LOG:0]   cnt_t;

    localparam page_t                   PG_LAST = page_t'(PAGE_NUM - 1);
    localparam page_t                   PG_ONE  = page_t'(1);
    localparam cnt_t                    CNT_ONE = cnt_t'(1);
    localparam logic [QUEUE_ID_WIDTH:0] QN      = (QUEUE_ID_WIDTH+1)'(QUEUE_NUM);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                    r_state, w_state_nxt;
    page_t                     r_init_cnt;
    page_t                     r_next [PAGE_NUM];
    page_t                     r_head [QUEUE_NUM];
    page_t                     r_tail [QUEUE_NUM];
    page_t                     r_free_head, r_free_tail;
    cnt_t                      r_free_count;
    logic [QUEUE_NUM-1:0]      r_qempty;
    logic                      r_init_done;
    logic                      r_req_op;
    logic [QUEUE_ID_WIDTH-1:0] r_req_queue;
    page_t                     r_rsp_page;
    logic                      r_rsp_error;
`ifdef LINK_QUEUE_STAT_EN
    cnt_t                      r_qcnt [QUEUE_NUM];
`endif

    logic                      w_q_ok;
    logic [QI_W-1:0]           w_qi;
    logic                      w_err;
    page_t                     w_enq_page, w_deq_page;

    // Request decode: a legal queue index, and whether the op can be served
    always_comb begin
        w_q_ok     = ({1'b0, r_req_queue} < QN);
        w_qi       = w_q_ok ? r_req_queue[QI_W-1:0] : '0;
        w_enq_page = r_free_head;
        w_deq_page = r_head[w_qi];
        w_err      = !w_q_ok
                   || (!r_req_op && (r_free_count == '0))
                   || ( r_req_op && r_qempty[w_qi]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: INIT runs once per page, then each request takes 3 cycles
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT: if (r_init_cnt == PG_LAST) w_state_nxt = S_IDLE;
            S_IDLE: if (i_req_valid)           w_state_nxt = S_EXEC;
            S_EXEC:                            w_state_nxt = S_RESP;
            S_RESP:                            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_INIT;
        endcase
    end

    // Link tables, free list and response registers; at most one next[] write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt   <= '0;
            r_free_head  <= '0;
            r_free_tail  <= '0;
            r_free_count <= '0;
            r_qempty     <= '1;
            r_init_done  <= 1'b0;
            r_req_op     <= 1'b0;
            r_req_queue  <= '0;
            r_rsp_page   <= '0;
            r_rsp_error  <= 1'b0;
            for (int i = 0; i < PAGE_NUM; i++) r_next[i] <= '0;
            for (int q = 0; q < QUEUE_NUM; q++) begin
                r_head[q] <= '0;
                r_tail[q] <= '0;
`ifdef LINK_QUEUE_STAT_EN
                r_qcnt[q] <= '0;
`endif
            end
        end else begin
            case (r_state)
                S_INIT: begin
                    // Chain page i to i+1; the last entry's link is never followed
                    r_next[r_init_cnt] <= r_init_cnt + PG_ONE;
                    r_free_count       <= r_free_count + CNT_ONE;
                    r_init_cnt         <= r_init_cnt + PG_ONE;
                    if (r_init_cnt == PG_LAST) begin
                        r_free_head <= '0;
                        r_free_tail <= PG_LAST;
                        r_init_done <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_req_op    <= i_req_op;
                        r_req_queue <= i_req_queue;
                    end
                end
                S_EXEC: begin
                    if (w_err) begin
                        r_rsp_error <= 1'b1;
                        r_rsp_page  <= '0;
                    end else if (!r_req_op) begin
                        // Enqueue: pop free head, append to queue tail
                        r_rsp_error  <= 1'b0;
                        r_rsp_page   <= w_enq_page;
                        r_free_head  <= r_next[w_enq_page];
                        r_free_count <= r_free_count - CNT_ONE;
                        if (r_qempty[w_qi]) r_head[w_qi] <= w_enq_page;
                        else                r_next[r_tail[w_qi]] <= w_enq_page;
                        r_tail[w_qi]   <= w_enq_page;
                        r_qempty[w_qi] <= 1'b0;
`ifdef LINK_QUEUE_STAT_EN
                        r_qcnt[w_qi]   <= r_qcnt[w_qi] + CNT_ONE;
`endif
                    end else begin
                        // Dequeue: pop queue head, append to free tail
                        r_rsp_error <= 1'b0;
                        r_rsp_page  <= w_deq_page;
                        if (r_head[w_qi] == r_tail[w_qi]) r_qempty[w_qi] <= 1'b1;
                        else                              r_head[w_qi]   <= r_next[w_deq_page];
                        if (r_free_count == '0) r_free_head <= w_deq_page;
                        else                    r_next[r_free_tail] <= w_deq_page;
                        r_free_tail  <= w_deq_page;
                        r_free_count <= r_free_count + CNT_ONE;
`ifdef LINK_QUEUE_STAT_EN
                        r_qcnt[w_qi] <= r_qcnt[w_qi] - CNT_ONE;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_rsp_valid   = (r_state == S_RESP);
    assign o_rsp_page    = r_rsp_page;
    assign o_rsp_error   = r_rsp_error;
    assign o_queue_empty = r_qempty;
    assign o_free_count  = r_free_count;
    assign o_init_done   = r_init_done;

`ifdef LINK_QUEUE_STAT_EN
    for (genvar q = 0; q < QUEUE_NUM; q++) begin : g_qcnt
        assign o_queue_count[q*(PAGE_NUM_LOG+1) +: (PAGE_NUM_LOG+1)] = r_qcnt[q];
    end
`endif

endmodule

// File: tb/tb_link_page_queue_manager.sv
// Bench for link_page_queue_manager (PAGE_NUM_LOG=3, QUEUE_NUM=4, 3-bit queue id).
// Reference: a free-list queue plus one queue per data queue; the expected
// outputs are refreshed on a request timeline and checked on every falling edge.
module tb_link_page_queue_manager;

    localparam int PL = 3;
    localparam int QN = 4;
    localparam int QW = 3;
    localparam int PN = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          i_req_op = 1'b0;
    logic [QW-1:0] i_req_queue = '0;
    logic          o_req_ready, o_rsp_valid, o_rsp_error, o_init_done;
    logic [PL-1:0] o_rsp_page;
    logic [QN-1:0] o_queue_empty;
    logic [PL:0]   o_free_count;
`ifdef LINK_QUEUE_STAT_EN
    logic [QN*(PL+1)-1:0] o_queue_count;
`endif

    link_page_queue_manager #(.PAGE_NUM_LOG(PL), .QUEUE_NUM(QN), .QUEUE_ID_WIDTH(QW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_queue(i_req_queue),
        .o_rsp_valid(o_rsp_valid), .o_rsp_page(o_rsp_page), .o_rsp_error(o_rsp_error),
        .o_queue_empty(o_queue_empty), .o_free_count(o_free_count), .o_init_done(o_init_done)
`ifdef LINK_QUEUE_STAT_EN
        , .o_queue_count(o_queue_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int fq[$];
    int qq[QN][$];
    int e_ready, e_rv, e_page, e_err, e_fc, e_qe, e_init;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        chk("req_ready",   int'(o_req_ready),   e_ready);
        chk("rsp_valid",   int'(o_rsp_valid),   e_rv);
        chk("rsp_page",    int'(o_rsp_page),    e_page);
        chk("rsp_error",   int'(o_rsp_error),   e_err);
        chk("free_count",  int'(o_free_count),  e_fc);
        chk("queue_empty", int'(o_queue_empty), e_qe);
        chk("init_done",   int'(o_init_done),   e_init);
`ifdef LINK_QUEUE_STAT_EN
        for (int q = 0; q < QN; q++)
            chk("queue_count", int'(o_queue_count[q*(PL+1) +: (PL+1)]), qq[q].size());
`endif
    end

    task automatic refresh_levels();
        e_fc = fq.size();
        e_qe = 0;
        for (int q = 0; q < QN; q++) if (qq[q].size() == 0) e_qe |= (1 << q);
    endtask

    // Reference operation: returns page/error and updates the lists
    task automatic model_op(input int op, input int q);
        int pg;
        bit er;
        pg = 0;
        er = 1'b0;
        if (q >= QN) er = 1'b1;
        else if (op == 0) begin
            if (fq.size() == 0) er = 1'b1;
            else begin pg = fq.pop_front(); qq[q].push_back(pg); end
        end else begin
            if (qq[q].size() == 0) er = 1'b1;
            else begin pg = qq[q].pop_front(); fq.push_back(pg); end
        end
        e_err  = er ? 1 : 0;
        e_page = er ? 0 : pg;
        refresh_levels();
    endtask

    task automatic noise();
        i_req_valid = 1'($urandom_range(0, 1));
        i_req_op    = 1'($urandom_range(0, 1));
        i_req_queue = QW'($urandom_range(0, 7));
    endtask

    // Reset (possibly mid-operation), then follow the 8-cycle free-list build
    task automatic do_reset();
        rst_n = 1'b0;
        i_req_valid = 1'b0;
        e_ready = 0; e_rv = 0; e_page = 0; e_err = 0; e_fc = 0; e_qe = 4'hF; e_init = 0;
        fq.delete();
        for (int q = 0; q < QN; q++) qq[q].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= PN; k++) begin
            if (k > 1) noise();
            @(posedge clk); #1;
            e_fc = k;
        end
        i_req_valid = 1'b0;
        for (int p = 0; p < PN; p++) fq.push_back(p);
        e_ready = 1;
        e_init  = 1;
    endtask

    // One request from IDLE; returns the response the DUT showed
    task automatic do_req(input int op, input int q, output int pg, output int er);
        i_req_valid = 1'b1;
        i_req_op    = 1'(op);
        i_req_queue = QW'(q);
        @(posedge clk); #1;
        e_ready = 0;
        noise();
        @(posedge clk); #1;
        e_rv = 1;
        model_op(op, q);
        pg = int'(o_rsp_page);
        er = int'(o_rsp_error);
        noise();
        @(posedge clk); #1;
        e_rv = 0;
        e_ready = 1;
        i_req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pg, er;
        do_reset();
        chk("init_fc_lit", int'(o_free_count), 8);
        chk("init_qe_lit", int'(o_queue_empty), 15);

        // Enqueue 3 onto q0
        for (int i = 0; i < 3; i++) begin
            do_req(0, 0, pg, er);
            chk("enq_q0_page_lit", pg, i);
            chk("enq_q0_err_lit", er, 0);
        end
        chk("enq_fc_lit", int'(o_free_count), 5);
        chk("enq_qe0_lit", int'(o_queue_empty[0]), 0);

        // Dequeue them back in FIFO order
        for (int i = 0; i < 3; i++) begin
            do_req(1, 0, pg, er);
            chk("deq_q0_page_lit", pg, i);
        end
        chk("deq_qe0_lit", int'(o_queue_empty[0]), 1);
        chk("deq_fc_lit", int'(o_free_count), 8);

        // Errors: empty queue, out-of-range ids
        do_req(1, 2, pg, er);
        chk("deq_empty_err_lit", er, 1);
        chk("deq_empty_page_lit", pg, 0);
        do_req(1, 5, pg, er);
        chk("bad_id_deq_err_lit", er, 1);
        do_req(0, 7, pg, er);
        chk("bad_id_enq_err_lit", er, 1);
        chk("bad_id_fc_lit", int'(o_free_count), 8);

        // Exhaust free list, then one more enqueue
        for (int i = 0; i < PN; i++) do_req(0, i % QN, pg, er);
        do_req(0, 1, pg, er);
        chk("full_enq_err_lit", er, 1);
        chk("full_fc_lit", int'(o_free_count), 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            do_req($urandom_range(0, 1), $urandom_range(0, 5), pg, er);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset while a request is in EXEC
        do_req(0, 3, pg, er);
        i_req_valid = 1'b1; i_req_op = 1'b0; i_req_queue = QW'(1);
        @(posedge clk); #1;
        e_ready = 0;
        do_reset();
        chk("rst_exec_fc_lit", int'(o_free_count), 8);
        chk("rst_exec_qe_lit", int'(o_queue_empty), 15);

        // Recycled page goes to the free tail
        do_req(0, 0, pg, er);
        chk("recyc_enq_lit", pg, 0);
        do_req(1, 0, pg, er);
        chk("recyc_deq_lit", pg, 0);
        for (int i = 0; i < PN; i++) begin
            do_req(0, 3, pg, er);
            chk("recyc_order_lit", pg, (i < 7) ? i + 1 : 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
